imem_loader: RTL

- Instruction-memory responder for the core's fetch interface. It returns a 32-bit instruction for the fetch address the core drives.
- It also includes a byte-serial program loader with a valid/ready handshake. The loader fills the memory and holds the core in reset while loading.
- Sits at SoC top beside the core: the core's instruction address output feeds inst_addr_i, and inst_o feeds the core's instruction input. core_rst_o gates the core's rst.

---
 rtl/imem_loader_pkg.sv | 13 +
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_ram.sv | 24 ++
 rtl/imem_loader.sv | 120 ++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory responder and its byte-serial loader.
package imem_loader_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_LOAD,
    ST_RELEASE
  } ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader handshake bundle: session control, byte stream and status back to the source.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic              ld_start_i;
  logic [ADDR_W:0]   ld_len_i;
  logic              ld_abort_i;
  logic [7:0]        ld_byte_i;
  logic              ld_valid_i;
  logic              ld_ready_o;
  logic              ld_done_o;
  logic [ADDR_W:0]   ld_count_o;

  modport master (
    output ld_start_i, ld_len_i, ld_abort_i, ld_byte_i, ld_valid_i,
    input  ld_ready_o, ld_done_o, ld_count_o
  );

  modport slave (
    input  ld_start_i, ld_len_i, ld_abort_i, ld_byte_i, ld_valid_i,
    output ld_ready_o, ld_done_o, ld_count_o
  );

endinterface

// File: rtl/imem_loader_ram.sv
// DEPTH x 32 instruction store: one synchronous write port, one asynchronous read port.
module imem_ram #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory responder with a byte-serial program loader that holds the core
// in reset while the memory is being filled.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned ADDR_W    = 12,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst_addr_i,
  output logic [31:0]         inst_o,
  imem_loader_if.slave        ld,
  output logic                core_rst_o
);

  localparam logic [ADDR_W:0] DEPTH_W     = (ADDR_W+1)'(DEPTH);
  localparam ld_state_t       RESET_STATE = BOOT_HOLD ? ST_HOLD : ST_RUN;

  ld_state_t         state_q, state_d;
  logic [ADDR_W:0]   len_q, count_q, len_in, count_inc;
  logic [ADDR_W-1:0] ptr_q;
  logic [1:0]        idx_q;
  logic [23:0]       asm_q;
  logic              start_load, accept, word_we;
  logic [31:0]       ram_rdata;
  logic              addr_oob;
  logic [1:0]        unused_addr_bits;

  assign len_in    = (ld.ld_len_i > DEPTH_W) ? DEPTH_W : ld.ld_len_i;
  assign count_inc = count_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort wins over a byte presented in the same cycle, so accept is gated by it.
  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    accept     = 1'b0;
    word_we    = 1'b0;
    case (state_q)
      ST_HOLD, ST_RUN: begin
        if (ld.ld_start_i) begin
          start_load = 1'b1;
          state_d    = (len_in == '0) ? ST_RELEASE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld.ld_abort_i) begin
          state_d = ST_HOLD;
        end else if (ld.ld_valid_i) begin
          accept = 1'b1;
          if (idx_q == 2'd3) begin
            word_we = 1'b1;
            if (count_inc == len_q) begin
              state_d = ST_RELEASE;
            end
          end
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      default:    state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
    end else if (start_load) begin
      len_q   <= len_in;
      count_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else if (accept) begin
      idx_q <= idx_q + 2'd1;
      case (idx_q)
        2'd0: asm_q[7:0]   <= ld.ld_byte_i;
        2'd1: asm_q[15:8]  <= ld.ld_byte_i;
        2'd2: asm_q[23:16] <= ld.ld_byte_i;
        default: begin
          ptr_q   <= ptr_q + 1'b1;
          count_q <= count_inc;
        end
      endcase
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (word_we),
    .waddr (ptr_q),
    .wdata ({ld.ld_byte_i, asm_q}),
    .raddr (inst_addr_i[ADDR_W+1:2]),
    .rdata (ram_rdata)
  );

  assign unused_addr_bits = inst_addr_i[1:0];
  assign addr_oob         = |inst_addr_i[31:ADDR_W+2];

  assign inst_o        = (state_q == ST_RUN && !addr_oob) ? ram_rdata : INST_NOP;
  assign core_rst_o    = (state_q != ST_RUN);
  assign ld.ld_ready_o = (state_q == ST_LOAD);
  assign ld.ld_done_o  = (state_q == ST_RELEASE);
  assign ld.ld_count_o = count_q;

endmodule
